// File: rtl/voice_motion_ctrl.sv
// rtl/voice_motion_ctrl.sv - voice-driven walk/jump motion controller for one character
module voice_motion_ctrl #(
    parameter logic [9:0] X_END   = 10'd600,
    parameter logic [7:0] H_MAX   = 8'd100,
    parameter logic [5:0] JUMP_HI = 6'd8,
    parameter logic [5:0] JUMP_LO = 6'd4,
    parameter logic [5:0] GRAVITY = 6'd1
) (
    input  logic       clk_60hz,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] pitch,
    input  logic       vol,
    output logic [9:0] x_pos,
    output logic [7:0] height,
    output logic [1:0] state,
    output logic       land,
    output logic       done
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GROUND = 2'b01;
    localparam logic [1:0] AIR    = 2'b10;
    localparam logic [1:0] DONE   = 2'b11;

    logic [1:0]        pitch_s1;
    logic [1:0]        pitch_s;
    logic signed [6:0] vy;
    logic signed [8:0] next_h;
    logic signed [6:0] vy_grav;
    logic [9:0]        x_step;

    // Pitch comes from the analyser clock domain; bring it across with two flops.
    always_ff @(posedge clk_60hz) begin
        if (!resetn) begin
            pitch_s1 <= 2'b00;
            pitch_s  <= 2'b00;
        end else begin
            pitch_s1 <= pitch;
            pitch_s  <= pitch_s1;
        end
    end

    // Candidate next height (9-bit signed so both ground and ceiling crossings show), gravity step and saturating x step.
    always_comb begin
        next_h  = $signed({1'b0, height}) + $signed({{2{vy[6]}}, vy});
        vy_grav = vy - $signed({1'b0, GRAVITY});
        x_step  = (x_pos == X_END) ? x_pos : x_pos + 10'd1;
    end

    // Motion state machine: reset, then enable=0, then per-state behaviour.
    always_ff @(posedge clk_60hz) begin
        if (!resetn || !enable) begin
            state  <= IDLE;
            x_pos  <= 10'd0;
            height <= 8'd0;
            vy     <= 7'sd0;
            land   <= 1'b0;
        end else begin
            land <= 1'b0;
            case (state)
                IDLE: begin
                    state <= GROUND;
                end
                GROUND: begin
                    if (x_pos == X_END) begin
                        state <= DONE;
                    end else if (vol) begin
                        x_pos <= x_step;
                        if (pitch_s == 2'b11) begin
                            vy    <= $signed({1'b0, JUMP_HI});
                            state <= AIR;
                        end else if (pitch_s == 2'b01) begin
                            vy    <= $signed({1'b0, JUMP_LO});
                            state <= AIR;
                        end
                    end
                end
                AIR: begin
                    x_pos <= x_step;
                    if (next_h <= 9'sd0) begin
                        height <= 8'd0;
                        vy     <= 7'sd0;
                        land   <= 1'b1;
                        state  <= (x_pos == X_END) ? DONE : GROUND;
                    end else if (next_h >= $signed({1'b0, H_MAX})) begin
                        // Velocity is zeroed at the ceiling and this frame's gravity applied, so the fall starts next frame.
                        height <= H_MAX;
                        vy     <= 7'sd0 - $signed({1'b0, GRAVITY});
                    end else begin
                        height <= next_h[7:0];
                        vy     <= vy_grav;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_voice_motion_ctrl.sv
// tb/tb_voice_motion_ctrl.sv - self-checking bench for voice_motion_ctrl
module tb_voice_motion_ctrl;

    logic clk_60hz = 1'b0;
    always #5 clk_60hz = ~clk_60hz;

    logic       rn     [0:1];
    logic       en     [0:1];
    logic [1:0] pit    [0:1];
    logic       vl     [0:1];
    logic [9:0] x_pos  [0:1];
    logic [7:0] height [0:1];
    logic [1:0] state  [0:1];
    logic       land   [0:1];
    logic       done   [0:1];

    voice_motion_ctrl dut (
        .clk_60hz(clk_60hz), .resetn(rn[0]), .enable(en[0]), .pitch(pit[0]), .vol(vl[0]),
        .x_pos(x_pos[0]), .height(height[0]), .state(state[0]), .land(land[0]), .done(done[0])
    );

    voice_motion_ctrl #(.X_END(10'd50), .JUMP_HI(6'd20)) dut_c (
        .clk_60hz(clk_60hz), .resetn(rn[1]), .enable(en[1]), .pitch(pit[1]), .vol(vl[1]),
        .x_pos(x_pos[1]), .height(height[1]), .state(state[1]), .land(land[1]), .done(done[1])
    );

    int p_xend [0:1] = '{600, 50};
    int p_hi   [0:1] = '{8, 20};
    int p_lo   [0:1] = '{4, 4};
    int p_hmax [0:1] = '{100, 100};
    int p_grav [0:1] = '{1, 1};

    // Reference model: 0 idle, 1 ground, 2 air, 3 done
    int m_st [0:1], m_x [0:1], m_h [0:1], m_v [0:1], m_land [0:1], m_p1 [0:1], m_p2 [0:1];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int w;
        logic rn;
        logic en;
        logic [1:0] p;
        logic v;
        int eh;
        int ex;
        int est;
        int el;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input int w, input int r, input int e, input int p, input int v,
                                input int eh, input int ex, input int est, input int el);
        vec_t t;
        t.w = w; t.rn = (r != 0); t.en = (e != 0); t.p = 2'(p); t.v = (v != 0);
        t.eh = eh; t.ex = ex; t.est = est; t.el = el;
        vecs.push_back(t);
    endfunction

    function automatic int sat_inc(input int x, input int lim);
        return (x + 1 > lim) ? lim : x + 1;
    endfunction

    task automatic model_step(input int i);
        int pc, nxt, ox, jv;
        if (!rn[i]) begin
            m_st[i] = 0; m_x[i] = 0; m_h[i] = 0; m_v[i] = 0; m_land[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
        end else begin
            pc = m_p2[i];
            m_p2[i] = m_p1[i];
            m_p1[i] = int'(pit[i]);
            m_land[i] = 0;
            if (!en[i]) begin
                m_st[i] = 0; m_x[i] = 0; m_h[i] = 0; m_v[i] = 0;
            end else if (m_st[i] == 0) begin
                m_st[i] = 1;
            end else if (m_st[i] == 1) begin
                if (m_x[i] == p_xend[i]) m_st[i] = 3;
                else if (vl[i]) begin
                    jv = (pc == 3) ? p_hi[i] : (pc == 1) ? p_lo[i] : 0;
                    m_x[i] = sat_inc(m_x[i], p_xend[i]);
                    if (jv != 0) begin m_v[i] = jv; m_st[i] = 2; end
                end
            end else if (m_st[i] == 2) begin
                ox = m_x[i];
                nxt = m_h[i] + m_v[i];
                m_x[i] = sat_inc(m_x[i], p_xend[i]);
                if (nxt <= 0) begin
                    m_h[i] = 0; m_v[i] = 0; m_land[i] = 1;
                    m_st[i] = (ox == p_xend[i]) ? 3 : 1;
                end else if (nxt >= p_hmax[i]) begin
                    m_h[i] = p_hmax[i]; m_v[i] = -p_grav[i];
                end else begin
                    m_h[i] = nxt; m_v[i] = m_v[i] - p_grav[i];
                end
            end
        end
    endtask

    task automatic check_model(input int i);
        n_checks++;
        if (state[i] !== 2'(m_st[i]) || x_pos[i] !== 10'(m_x[i]) || height[i] !== 8'(m_h[i]) ||
            land[i] !== 1'(m_land[i]) || done[i] !== (m_st[i] == 3)) begin
            n_fail++;
            $display("FAIL model[%0d] t=%0t: got st=%0d x=%0d h=%0d land=%0d done=%0d, want st=%0d x=%0d h=%0d land=%0d done=%0d",
                     i, $time, state[i], x_pos[i], height[i], land[i], done[i],
                     m_st[i], m_x[i], m_h[i], m_land[i], (m_st[i] == 3));
        end
    endtask

    task automatic tick();
        @(posedge clk_60hz);
        model_step(0);
        model_step(1);
        #1;
        check_model(0);
        check_model(1);
    endtask

    initial begin
        int hi_h [16] = '{8, 15, 21, 26, 30, 33, 35, 36, 36, 35, 33, 30, 26, 21, 15, 8};
        int lo_h [8]  = '{4, 7, 9, 10, 10, 9, 7, 4};
        int ce_h [19] = '{20, 39, 57, 74, 90, 100, 99, 97, 94, 90, 85, 79, 72, 64, 55, 45, 34, 22, 9};
        vec_t v;
        int w;

        for (int i = 0; i < 2; i++) begin
            rn[i] = 1'b0; en[i] = 1'b0; pit[i] = 2'b00; vl[i] = 1'b0;
            m_st[i] = 0; m_x[i] = 0; m_h[i] = 0; m_v[i] = 0; m_land[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
        end

        // default instance: reset, walk, high jump, low jump, reset mid-jump
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 10; k++) add(0, 1, 1, 0, 1, 0, k, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 1, 3, 0, 0, 10, 1, 0);
        add(0, 1, 1, 3, 1, 0, 11, 2, 0);
        for (int k = 0; k < 16; k++) add(0, 1, 1, 0, 0, hi_h[k], 12 + k, 2, 0);
        add(0, 1, 1, 0, 0, 0, 28, 1, 1);
        add(0, 1, 1, 0, 0, 0, 28, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 1, 1, 0, 0, 28, 1, 0);
        add(0, 1, 1, 1, 1, 0, 29, 2, 0);
        for (int k = 0; k < 8; k++) add(0, 1, 1, (k % 2 == 1) ? 3 : 1, (k % 2 == 0) ? 1 : 0, lo_h[k], 30 + k, 2, 0);
        add(0, 1, 1, 3, 1, 0, 38, 1, 1);
        add(0, 1, 1, 0, 0, 0, 38, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 1, 3, 0, 0, 38, 1, 0);
        add(0, 1, 1, 3, 1, 0, 39, 2, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, hi_h[k], 40 + k, 2, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1, 0);

        // ceiling instance: clamp at H_MAX, then walk to course end, hold, release
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) add(1, 1, 1, 3, 0, 0, 0, 1, 0);
        add(1, 1, 1, 3, 1, 0, 1, 2, 0);
        for (int k = 0; k < 19; k++) add(1, 1, 1, 0, 0, ce_h[k], 2 + k, 2, 0);
        add(1, 1, 1, 0, 0, 0, 21, 1, 1);
        add(1, 1, 1, 0, 0, 0, 21, 1, 0);
        for (int k = 22; k <= 50; k++) add(1, 1, 1, 0, 1, 0, k, 1, 0);
        add(1, 1, 1, 3, 1, 0, 50, 3, 0);
        for (int k = 0; k < 3; k++) add(1, 1, 1, 3, 1, 0, 50, 3, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            w = v.w;
            rn[w] = v.rn; en[w] = v.en; pit[w] = v.p; vl[w] = v.v;
            tick();
            n_checks++;
            if (state[w] !== 2'(v.est) || height[w] !== 8'(v.eh) || land[w] !== 1'(v.el) ||
                done[w] !== (v.est == 3) || (v.ex >= 0 && x_pos[w] !== 10'(v.ex))) begin
                n_fail++;
                $display("FAIL vec[%0d] inst%0d: got st=%0d x=%0d h=%0d land=%0d done=%0d, want st=%0d x=%0d h=%0d land=%0d",
                         n, w, state[w], x_pos[w], height[w], land[w], done[w], v.est, v.ex, v.eh, v.el);
            end
        end

        // randomized run on both instances against the model
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 2; i++) begin
                rn[i]  = ($urandom_range(0, 299) != 0);
                en[i]  = ($urandom_range(0, 149) != 0);
                pit[i] = 2'($urandom_range(0, 3));
                vl[i]  = ($urandom_range(0, 9) < 6);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_motion_ctrl.md
VOICE_MOTION_CTRL -- requirements
Module: voice_motion_ctrl

Interface
REQ-001 Parameter: X_END, default 10'd600, final x position of the course.
REQ-002 Parameter: H_MAX, default 8'd100, height ceiling.
REQ-003 Parameter: JUMP_HI, default 6'd8, takeoff velocity for high pitch (11).
REQ-004 Parameter: JUMP_LO, default 6'd4, takeoff velocity for mid pitch (01).
REQ-005 Parameter: GRAVITY, default 6'd1, velocity decrement per frame.
REQ-006 Port: clk_60hz  in  1  frame clock; all state updates on its rising edge.
REQ-007 Port: resetn  in  1  reset, synchronous, active-low.
REQ-008 Port: enable  in  1  game run; 0 forces IDLE.
REQ-009 Port: pitch  in  2  pitch class from the analyser (00 low, 01 mid, 11 high, 10 treated as 00); asynchronous to clk_60hz.
REQ-010 Port: vol  in  1  loudness flag from the analyser, already in the clk_60hz domain.
REQ-011 Port: x_pos  out  10  character horizontal position, unsigned.
REQ-012 Port: height  out  8  character height above ground, unsigned.
REQ-013 Port: state  out  2  FSM state: IDLE=00, GROUND=01, AIR=10, DONE=11.
REQ-014 Port: land  out  1  one-frame pulse on the frame the character touches ground.
REQ-015 Port: done  out  1  high when state==DONE.

Function
REQ-016 pitch SHALL pass through a two-flop synchronizer; decisions use the second stage (pitch_s). vol SHALL be used directly.
REQ-017 Vertical velocity vy SHALL be a 7-bit signed register; height arithmetic SHALL be done at 9 bits signed to detect underflow and overflow.
REQ-018 IDLE: x_pos=0, height=0, vy=0, land=0. Transition to GROUND when enable=1.
REQ-019 GROUND, vol=1, pitch_s==11: vy<=JUMP_HI, height unchanged, x_pos+1 (saturating), state<=AIR.
REQ-020 GROUND, vol=1, pitch_s==01: same as REQ-019 with vy<=JUMP_LO.
REQ-021 GROUND, vol=1, pitch_s in {00,10}: x_pos+1 (saturating), remain GROUND.
REQ-022 GROUND, vol=0: all registers hold.
REQ-023 GROUND, x_pos==X_END: state<=DONE. This has priority over jump and walk.
REQ-024 AIR, each frame: next=height+vy; x_pos+1 (saturating at X_END) regardless of vol; vy<=vy-GRAVITY.
REQ-025 AIR, next<=0: height<=0, vy<=0, land<=1, state<=GROUND. If x_pos==X_END, state<=DONE instead.
REQ-026 AIR, next>=H_MAX: height<=H_MAX and vy<=0; the character then falls under gravity.
REQ-027 AIR, otherwise: height<=next. pitch and vol SHALL be ignored in AIR.
REQ-028 DONE: all outputs hold, done=1. Exit to IDLE only when enable=0.
REQ-029 enable=0 in any state SHALL force IDLE on the next edge and clear x_pos, height, vy and land. This has priority over everything except reset.
REQ-030 land SHALL be high for exactly one frame per landing and 0 otherwise.

Reset
REQ-031 resetn=0 at a clock edge SHALL set state=IDLE, x_pos=0, height=0, vy=0, land=0, done=0 and clear both synchronizer stages. This has top priority, including mid-jump.

Verification
REQ-032 Reset mid-jump (height 21): assert resetn=0 for 1 frame -> next frame all outputs 0, state=00.
REQ-033 enable=1, vol=1, pitch=00 for 10 frames -> x_pos increments by 1 per frame, state stays 01, height=0.
REQ-034 High jump: GROUND, pitch=11 held 3+ frames, then vol=1 for one frame -> heights 8,15,21,26,30,33,35,36,36,35,33,30,26,21,15,8, then 0 with land=1 on takeoff+17, state=01.
REQ-035 Low jump: pitch=01, vol=1 -> heights 4,7,9,10,10,9,7,4, then 0 with land=1 on takeoff+9. vol/pitch changes while airborne have no effect.
REQ-036 Ceiling: JUMP_HI=20, H_MAX=100 -> heights 20,39,57,74,90,100(clamped, vy=0), then 99,97 and so on.
REQ-037 Course end: walk to x_pos=X_END -> next frame state=11, done=1, outputs hold; enable=0 -> IDLE and outputs cleared.
